divider_4bit_recon: RTL and testbench
=====================================

// Module: divider_4bit_recon
// PURPOSE
// - Sequential inverse of the 4-bit divider. Takes a quotient Q, divisor B and
//   remainder R, and rebuilds the dividend A = Q*B + R one quotient bit per
//   cycle, MSB first, using shift-add.
// - Also reports whether {Q,R} is a legal division result for B. The bench
//   uses it as a round-trip checker behind the divider; datapaths use it as
//   a small multiply-accumulate unit.
// PARAMETERS
// - Q_W  4  quotient width; equals the iteration count
// - B_W  2  divisor width
// - R_W  4  remainder width
// - A_W  4  width of a legal dividend; used for the fits check
// - P_W  7  accumulator/result width; must equal max(Q_W+B_W, R_W)+1
// PORTS
// - clk        in   1    single clock; all state changes on its rising edge
// - rst        in   1    reset; synchronous, active-high
// - in_valid   in   1    Q/B/R are valid this cycle
// - in_ready   out  1    block can accept an operand set
// - q          in   Q_W  quotient
// - b          in   B_W  divisor
// - r          in   R_W  remainder
// - out_valid  out  1    result and flags are valid
// - out_ready  in   1    consumer takes the result
// - a_out      out  P_W  Q*B+R; exact, never truncated
// - div_zero   out  1    b==0
// - rem_ok     out  1    r<b (0 when b==0)
// - fits       out  1    a_out < 2**A_W
// - consistent out  1    !div_zero && rem_ok && fits
// BEHAVIOUR
// - Reset: state=IDLE. in_ready=1 in the cycle after reset.
//   out_valid=0, a_out=0 and all flags=0.
// - Reset overrides everything. A reset mid-computation discards the operands
//   and emits no result.
// - FSM states: IDLE, MUL, ADD, DONE.
//   - IDLE: in_ready=1. On in_valid, capture q, b and r; set acc=0 and
//     cnt=Q_W-1; go to MUL.
//   - MUL: acc = (acc<<1) + (q_reg[cnt] ? b_reg : 0), zero-extended to P_W.
//     At cnt==0 go to ADD; otherwise decrement cnt.
//   - ADD: acc = acc + r_reg. Register a_out and all flags. Go to DONE.
//   - DONE: out_valid=1. Outputs stay stable until out_ready=1.
//     - out_ready=1 and in_valid=0: go to IDLE.
//     - out_ready=1 and in_valid=1: capture the new operands in that same
//       cycle and go straight to MUL.
// - in_ready = (state==IDLE) || (state==DONE && out_ready). It is
//   combinational from out_ready only.
// - Latency: result is visible Q_W+1 clock edges after the accepting edge
//   (5 at default). With a consumer that never stalls, the start-to-start
//   interval is Q_W+2 cycles.
// - Operands are sampled only at the accept edge. Changes on q, b or r
//   afterwards have no effect.
// - Flags are computed from the captured operands and the final acc, and are
//   registered together with a_out.
// - div_zero=1 still gives a_out=R, because Q*0=0.
// - Nothing can overflow, since P_W covers the maximum
//   (2**Q_W-1)*(2**B_W-1) + 2**R_W-1.
// - Outside DONE: out_valid=0, and a_out and the flags keep their last
//   values. The bench must ignore them there.
// STRUCTURE
// - Shared package div_pkg:
//   - Q_W, B_W, R_W, A_W and P_W defaults, shared with the 4-bit divider.
//   - State encoding constants IDLE=2'd0, MUL=2'd1, ADD=2'd2, DONE=2'd3.
// - No sub-module. The shift-add step is one adder, kept inline.
// - Single registered FSM, with the datapath registers q_reg, b_reg, r_reg,
//   acc and cnt ($clog2(Q_W) bits).
// TESTING
// - q=4,b=3,r=1 -> a_out=13, div_zero=0, rem_ok=1, fits=1, consistent=1,
//   out_valid 5 edges after accept.
// - q=15,b=3,r=2 -> a_out=47, rem_ok=1, fits=0, consistent=0.
// - q=5,b=0,r=9 -> a_out=9, div_zero=1, rem_ok=0, consistent=0.
// - q=1,b=2,r=3 -> a_out=5, rem_ok=0, fits=1, consistent=0.
// - Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable,
//   in_ready=0. Raise out_ready with in_valid=1 (q=2,b=1,r=0) -> the same
//   edge accepts, the next result is 2, and no cycle is lost.
// - Assert rst during MUL -> next cycle IDLE, out_valid=0, in_ready=1.
//   A later q=3,b=3,r=0 -> 9. Also a random sweep of all 4x2x4-bit inputs
//   against a Q*B+R model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the 4-bit divider and its
// reconstruction (Q*B+R) companion.
package div_pkg;
  localparam int Q_W   = 4;
  localparam int B_W   = 2;
  localparam int R_W   = 4;
  localparam int A_W   = 4;
  localparam int P_W   = 7;
  localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/divider_4bit_recon_if.sv
// Operand/result handshake bundle for divider_4bit_recon; master drives
// operands and consumes results, slave is the reconstruction block.
interface divider_4bit_recon_if;
  import div_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] q;
  logic [B_W-1:0] b;
  logic [R_W-1:0] r;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] a_out;
  logic           div_zero;
  logic           rem_ok;
  logic           fits;
  logic           consistent;

  modport master (
    output in_valid, q, b, r, out_ready,
    input  in_ready, out_valid, a_out, div_zero, rem_ok, fits, consistent
  );

  modport slave (
    input  in_valid, q, b, r, out_ready,
    output in_ready, out_valid, a_out, div_zero, rem_ok, fits, consistent
  );
endinterface

// File: rtl/divider_4bit_recon.sv
// Rebuilds A = Q*B + R by MSB-first shift-add, one quotient bit per cycle, and
// flags whether {Q,R} is a legal division result; result Q_W+1 edges after accept.
module divider_4bit_recon
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  divider_4bit_recon_if.slave   bus
);

  localparam logic [P_W-1:0] A_LIM = P_W'(1) << A_W;

  state_t           state;
  logic [Q_W-1:0]   q_reg;
  logic [B_W-1:0]   b_reg;
  logic [R_W-1:0]   r_reg;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;

  logic             out_valid_reg;
  logic [P_W-1:0]   a_out_reg;
  logic             div_zero_reg;
  logic             rem_ok_reg;
  logic             fits_reg;
  logic             consistent_reg;

  logic             accept;
  logic [P_W-1:0]   sum;
  logic             b_zero;
  logic             r_lt_b;

  // A waiting result can be swapped for new operands on the same edge it is taken.
  assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum    = acc + P_W'(r_reg);
  assign b_zero = (b_reg == '0);
  assign r_lt_b = (r_reg < R_W'(b_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      q_reg          <= '0;
      b_reg          <= '0;
      r_reg          <= '0;
      acc            <= '0;
      cnt            <= '0;
      out_valid_reg  <= 1'b0;
      a_out_reg      <= '0;
      div_zero_reg   <= 1'b0;
      rem_ok_reg     <= 1'b0;
      fits_reg       <= 1'b0;
      consistent_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_reg <= bus.q;
            b_reg <= bus.b;
            r_reg <= bus.r;
            acc   <= '0;
            cnt   <= CNT_W'(Q_W - 1);
            state <= MUL;
          end
        end
        MUL: begin
          acc <= {acc[P_W-2:0], 1'b0} + (q_reg[cnt] ? P_W'(b_reg) : '0);
          if (cnt == '0) state <= ADD;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ADD: begin
          a_out_reg      <= sum;
          div_zero_reg   <= b_zero;
          rem_ok_reg     <= !b_zero && r_lt_b;
          fits_reg       <= (sum < A_LIM);
          consistent_reg <= !b_zero && r_lt_b && (sum < A_LIM);
          out_valid_reg  <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (bus.in_valid) begin
              q_reg <= bus.q;
              b_reg <= bus.b;
              r_reg <= bus.r;
              acc   <= '0;
              cnt   <= CNT_W'(Q_W - 1);
              state <= MUL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.a_out      = a_out_reg;
  assign bus.div_zero   = div_zero_reg;
  assign bus.rem_ok     = rem_ok_reg;
  assign bus.fits       = fits_reg;
  assign bus.consistent = consistent_reg;

endmodule

// File: tb/tb_divider_4bit_recon.sv
// Randomized and directed bench for divider_4bit_recon against a Q*B+R
// arithmetic model, including backpressure and mid-computation reset.
module tb_divider_4bit_recon;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_4bit_recon_if dif();

  divider_4bit_recon dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    dif.q = Q_W'($urandom);
    dif.b = B_W'($urandom);
    dif.r = R_W'($urandom);
  endtask

  // Reference: plain integer arithmetic on the operands as given.
  task automatic expect_result(input int q, input int b, input int r);
    int a;
    bit dz, rok, ft;
    a   = q * b + r;
    dz  = (b == 0);
    rok = (b != 0) && (r < b);
    ft  = (a < (1 << A_W));
    chk("a_out",      32'(dif.a_out),      32'(a));
    chk("div_zero",   32'(dif.div_zero),   32'(dz));
    chk("rem_ok",     32'(dif.rem_ok),     32'(rok));
    chk("fits",       32'(dif.fits),       32'(ft));
    chk("consistent", 32'(dif.consistent), 32'(!dz && rok && ft));
  endtask

  task automatic send(input int q, input int b, input int r);
    int n = 0;
    while (!dif.in_ready && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) chk("in_ready_timeout", 32'(n), 32'(0));
    dif.in_valid = 1'b1;
    dif.q = Q_W'(q);
    dif.b = B_W'(b);
    dif.r = R_W'(r);
    step();
    dif.in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    while (!dif.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk(tag, 32'(lat), 32'(Q_W + 1));
  endtask

  task automatic consume();
    dif.out_ready = 1'b1;
    step();
    dif.out_ready = 1'b0;
    chk("drained", 32'(dif.out_valid), 32'(0));
  endtask

  initial begin
    bit leaked;
    int q, b, r, stall;
    logic [P_W-1:0] held;

    rst = 1'b1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.q = '0;
    dif.b = '0;
    dif.r = '0;
    repeat (3) step();
    chk("rst_out_valid", 32'(dif.out_valid), 32'(0));
    chk("rst_a_out",     32'(dif.a_out),     32'(0));
    chk("rst_flags",     32'({dif.div_zero, dif.rem_ok, dif.fits, dif.consistent}), 32'(0));
    rst = 1'b0;
    step();
    chk("rst_in_ready",  32'(dif.in_ready),  32'(1));

    // Directed vectors covering each flag combination.
    send(4, 3, 1);  wait_out("lat_4_3_1");  expect_result(4, 3, 1);  consume();
    send(15, 3, 2); wait_out("lat_15_3_2"); expect_result(15, 3, 2); consume();
    send(5, 0, 9);  wait_out("lat_5_0_9");  expect_result(5, 0, 9);  consume();
    send(1, 2, 3);  wait_out("lat_1_2_3");  expect_result(1, 2, 3);  consume();

    // Stalled consumer, then take the result and new operands on one edge.
    send(7, 2, 1);
    wait_out("lat_bp");
    expect_result(7, 2, 1);
    repeat (3) begin
      step();
      chk("bp_out_valid", 32'(dif.out_valid), 32'(1));
      chk("bp_a_out",     32'(dif.a_out),     32'(15));
      chk("bp_in_ready",  32'(dif.in_ready),  32'(0));
    end
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.q = 4'd2;
    dif.b = 2'd1;
    dif.r = 4'd0;
    #1;
    chk("bp_in_ready_comb", 32'(dif.in_ready), 32'(1));
    step();
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b0;
    scramble();
    chk("bp_swap_out_valid", 32'(dif.out_valid), 32'(0));
    wait_out("lat_b2b");
    expect_result(2, 1, 0);
    consume();

    // Reset while in MUL discards the operation.
    send(9, 3, 4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(dif.out_valid), 32'(0));
    chk("midrst_in_ready",  32'(dif.in_ready),  32'(1));
    leaked = 1'b0;
    repeat (8) begin
      step();
      if (dif.out_valid) leaked = 1'b1;
    end
    chk("midrst_no_result", 32'(leaked), 32'(0));
    send(3, 3, 0); wait_out("lat_after_rst"); expect_result(3, 3, 0); consume();

    // Random sweep with occasional consumer stalls.
    for (int i = 0; i < 80; i++) begin
      q = $urandom_range(0, (1 << Q_W) - 1);
      b = $urandom_range(0, (1 << B_W) - 1);
      r = $urandom_range(0, (1 << R_W) - 1);
      send(q, b, r);
      wait_out("lat_rand");
      expect_result(q, b, r);
      stall = $urandom_range(0, 2);
      held  = dif.a_out;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("rand_hold", 32'({dif.out_valid, dif.a_out}), 32'({1'b1, held}));
      end
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
